// File: rtl/db_resp.sv
// db_resp -- SRIO target-side doorbell responder and NWRITE sink.
//
// Requests arrive on an AXI-Stream target port (treq_*). The first accepted
// beat of every packet is a HELLO header:
//   * FTYPE 4'hA (doorbell): a single-beat response goes out on tresp_*.
//     Info 16'h0101 is a self-check that is answered with the local busy
//     status; any other info is echoed and also handed to the application
//     on db_inform_*.
//   * FTYPE 4'h5 / TTYPE 4'h4 (NWRITE): payload beats are forwarded one cycle
//     later on nwr_* with incrementing addresses, plus a byte count and an
//     end-of-packet pulse. A packet longer than MAX_BEATS is cut off with an
//     error pulse.
//   * anything else is consumed and discarded.
//
// Ports
//   log_clk, log_rst_n                 clock, async active-low reset
//   target_busy_in                     application busy (sampled on doorbell)
//   treq_tvalid_in/tready_o/tlast_in   request handshake
//   treq_tdata_in/tkeep_in/tuser_in    request beat ([23:16] of tuser = src ID)
//   tresp_tvalid_o/tready_in/tlast_o   response handshake
//   tresp_tdata_o/tkeep_o/tuser_o      response beat
//   nwr_valid_o/data_o/keep_o/addr_o   NWRITE payload beat to local memory
//   nwr_done_o/err_o/bytes_o           end-of-packet, overrun, byte count
//   db_inform_valid_o/db_inform_o      non-self-check doorbell info
module db_resp #(
  parameter logic [7:0] SELF_ID   = 8'hF0,
  parameter int         MAX_BEATS = 32
) (
  input  logic        log_clk,
  input  logic        log_rst_n,
  input  logic        target_busy_in,
  // request stream
  input  logic        treq_tvalid_in,
  output logic        treq_tready_o,
  input  logic        treq_tlast_in,
  input  logic [63:0] treq_tdata_in,
  input  logic [7:0]  treq_tkeep_in,
  input  logic [31:0] treq_tuser_in,
  // response stream
  output logic        tresp_tvalid_o,
  input  logic        tresp_tready_in,
  output logic        tresp_tlast_o,
  output logic [63:0] tresp_tdata_o,
  output logic [7:0]  tresp_tkeep_o,
  output logic [31:0] tresp_tuser_o,
  // NWRITE payload
  output logic        nwr_valid_o,
  output logic [63:0] nwr_data_o,
  output logic [7:0]  nwr_keep_o,
  output logic [33:0] nwr_addr_o,
  output logic        nwr_done_o,
  output logic        nwr_err_o,
  output logic [11:0] nwr_bytes_o,
  // doorbell info to application
  output logic        db_inform_valid_o,
  output logic [15:0] db_inform_o
);

  localparam int KEEP_W = 8;
  localparam int BCNT_W = $clog2(MAX_BEATS + 1);

  localparam logic [3:0]  FT_DB      = 4'hA;
  localparam logic [3:0]  FT_NWR     = 4'h5;
  localparam logic [3:0]  TT_NWR     = 4'h4;
  localparam logic [15:0] INFO_CHECK = 16'h0101;
  localparam logic [15:0] INFO_BUSY  = 16'h01FF;
  localparam logic [15:0] INFO_IDLE  = 16'h0100;

  // HELLO header layout
  typedef struct packed {
    logic [7:0]  tid;
    logic [3:0]  ftype;
    logic [3:0]  ttype;
    logic        rsv0;
    logic [1:0]  prio;
    logic        rsv1;
    logic [7:0]  size;
    logic [1:0]  rsv2;
    logic [33:0] addr;   // doorbell info sits in addr[31:16]
  } hdr_t;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DB_RESP  = 2'd1,
    S_NWR_DATA = 2'd2,
    S_DROP     = 2'd3
  } state_t;

  state_t state, state_nxt;

  hdr_t        hdr;
  logic        acc;
  logic        is_db;
  logic        is_nwr;
  logic        overflow;
  logic [15:0] hdr_info;

  // latched doorbell context
  logic [7:0]  tid_r;
  logic [1:0]  prio_r;
  logic [7:0]  req_id_r;
  logic [15:0] info_r;
  logic        inform_r;   // doorbell info goes to the application
  logic        db_pend;    // doorbell header seen, response still owed

  // latched NWRITE context
  logic [33:0]       addr_r;
  logic [BCNT_W-1:0] beat_cnt;

  logic in_resp;
  logic unused_bits;

  function automatic logic [3:0] popcnt(input logic [KEEP_W-1:0] k);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < KEEP_W; i++) s = s + {3'b000, k[i]};
    return s;
  endfunction

  assign hdr      = hdr_t'(treq_tdata_in);
  assign hdr_info = hdr.addr[31:16];
  assign acc      = treq_tvalid_in & treq_tready_o;
  assign is_db    = (hdr.ftype == FT_DB);
  assign is_nwr   = (hdr.ftype == FT_NWR) && (hdr.ttype == TT_NWR);
  assign overflow = (beat_cnt == BCNT_W'(MAX_BEATS));
  assign in_resp  = (state == S_DB_RESP);

  // header fields that this endpoint does not act on
  assign unused_bits = ^{hdr.rsv0, hdr.rsv1, hdr.size, hdr.rsv2,
                         treq_tuser_in[31:24], treq_tuser_in[15:0]};

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge log_clk or negedge log_rst_n) begin
    if (!log_rst_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (acc) begin
          if (is_db)       state_nxt = treq_tlast_in ? S_DB_RESP : S_DROP;
          else if (is_nwr) state_nxt = treq_tlast_in ? S_IDLE    : S_NWR_DATA;
          else             state_nxt = treq_tlast_in ? S_IDLE    : S_DROP;
        end
      end
      S_DB_RESP: begin
        if (tresp_tready_in) state_nxt = S_IDLE;
      end
      S_NWR_DATA: begin
        if (acc) begin
          // an overrun beat carrying tlast already ends the packet
          if (overflow)           state_nxt = treq_tlast_in ? S_IDLE : S_DROP;
          else if (treq_tlast_in) state_nxt = S_IDLE;
        end
      end
      S_DROP: begin
        if (acc && treq_tlast_in) state_nxt = db_pend ? S_DB_RESP : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // tready is forced low while reset is held so nothing is taken in
    treq_tready_o     = log_rst_n & (state != S_DB_RESP);
    tresp_tvalid_o    = in_resp;
    tresp_tlast_o     = in_resp;
    tresp_tkeep_o     = '0;
    tresp_tdata_o     = '0;
    tresp_tuser_o     = '0;
    db_inform_valid_o = in_resp & tresp_tready_in & inform_r;
    db_inform_o       = '0;
    if (in_resp) begin
      tresp_tkeep_o = 8'hFF;
      tresp_tdata_o = {tid_r, FT_DB, 4'h0, 1'b0, prio_r, 1'b0, 12'h000,
                       info_r, 16'h0000};
      tresp_tuser_o = {8'h00, SELF_ID, 8'h00, req_id_r};
    end
    if (db_inform_valid_o) db_inform_o = info_r;
  end

  // ---------------------------------------------------------------------------
  // Context latches and NWRITE datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge log_clk or negedge log_rst_n) begin
    if (!log_rst_n) begin
      tid_r       <= '0;
      prio_r      <= '0;
      req_id_r    <= '0;
      info_r      <= '0;
      inform_r    <= 1'b0;
      db_pend     <= 1'b0;
      addr_r      <= '0;
      beat_cnt    <= '0;
      nwr_valid_o <= 1'b0;
      nwr_data_o  <= '0;
      nwr_keep_o  <= '0;
      nwr_addr_o  <= '0;
      nwr_done_o  <= 1'b0;
      nwr_err_o   <= 1'b0;
      nwr_bytes_o <= '0;
    end else begin
      nwr_valid_o <= 1'b0;
      nwr_done_o  <= 1'b0;
      nwr_err_o   <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (acc && is_db) begin
            tid_r    <= hdr.tid;
            // response priority is one above the request, capped at 3
            prio_r   <= (hdr.prio == 2'b11) ? 2'b11 : hdr.prio + 2'd1;
            req_id_r <= treq_tuser_in[23:16];
            db_pend  <= 1'b1;
            if (hdr_info == INFO_CHECK) begin
              info_r   <= target_busy_in ? INFO_BUSY : INFO_IDLE;
              inform_r <= 1'b0;
            end else begin
              info_r   <= hdr_info;
              inform_r <= 1'b1;
            end
          end else if (acc && is_nwr) begin
            addr_r      <= hdr.addr;
            beat_cnt    <= '0;
            nwr_bytes_o <= '0;
            // header-only NWRITE completes with zero bytes
            nwr_done_o  <= treq_tlast_in;
          end
        end
        S_NWR_DATA: begin
          if (acc) begin
            if (overflow) begin
              nwr_err_o <= 1'b1;
            end else begin
              nwr_valid_o <= 1'b1;
              nwr_data_o  <= treq_tdata_in;
              nwr_keep_o  <= treq_tkeep_in;
              nwr_addr_o  <= addr_r + {{(34-BCNT_W-3){1'b0}}, beat_cnt, 3'b000};
              nwr_bytes_o <= nwr_bytes_o + {8'h00, popcnt(treq_tkeep_in)};
              beat_cnt    <= beat_cnt + 1'b1;
              nwr_done_o  <= treq_tlast_in;
            end
          end
        end
        S_DB_RESP: begin
          if (tresp_tready_in) db_pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_db_resp.sv
// Directed bench for db_resp: doorbell self-check (idle/busy with response
// backpressure), integrity doorbell, multi-beat doorbell, NWRITE forwarding,
// header-only NWRITE, overrun, unknown FTYPE and reset mid-packet.
module tb_db_resp;

  logic        log_clk = 1'b0;
  logic        log_rst_n = 1'b0;
  logic        target_busy_in = 1'b0;
  logic        treq_tvalid_in = 1'b0;
  logic        treq_tready_o;
  logic        treq_tlast_in = 1'b0;
  logic [63:0] treq_tdata_in = '0;
  logic [7:0]  treq_tkeep_in = '0;
  logic [31:0] treq_tuser_in = '0;
  logic        tresp_tvalid_o;
  logic        tresp_tready_in = 1'b0;
  logic        tresp_tlast_o;
  logic [63:0] tresp_tdata_o;
  logic [7:0]  tresp_tkeep_o;
  logic [31:0] tresp_tuser_o;
  logic        nwr_valid_o;
  logic [63:0] nwr_data_o;
  logic [7:0]  nwr_keep_o;
  logic [33:0] nwr_addr_o;
  logic        nwr_done_o;
  logic        nwr_err_o;
  logic [11:0] nwr_bytes_o;
  logic        db_inform_valid_o;
  logic [15:0] db_inform_o;

  db_resp dut (
    .log_clk(log_clk), .log_rst_n(log_rst_n), .target_busy_in(target_busy_in),
    .treq_tvalid_in(treq_tvalid_in), .treq_tready_o(treq_tready_o),
    .treq_tlast_in(treq_tlast_in), .treq_tdata_in(treq_tdata_in),
    .treq_tkeep_in(treq_tkeep_in), .treq_tuser_in(treq_tuser_in),
    .tresp_tvalid_o(tresp_tvalid_o), .tresp_tready_in(tresp_tready_in),
    .tresp_tlast_o(tresp_tlast_o), .tresp_tdata_o(tresp_tdata_o),
    .tresp_tkeep_o(tresp_tkeep_o), .tresp_tuser_o(tresp_tuser_o),
    .nwr_valid_o(nwr_valid_o), .nwr_data_o(nwr_data_o), .nwr_keep_o(nwr_keep_o),
    .nwr_addr_o(nwr_addr_o), .nwr_done_o(nwr_done_o), .nwr_err_o(nwr_err_o),
    .nwr_bytes_o(nwr_bytes_o), .db_inform_valid_o(db_inform_valid_o),
    .db_inform_o(db_inform_o)
  );

  always #5 log_clk = ~log_clk;

  int checks = 0;
  int failures = 0;

  // event recorder, sampled on the falling edge
  int          nv_cnt, done_cnt, err_cnt, hs_cnt, inf_cnt;
  logic [33:0] nv_addr [0:63];
  logic [63:0] nv_data [0:63];
  logic [11:0] done_bytes;
  logic        done_with_valid;
  logic [63:0] hs_data;
  logic [31:0] hs_user;
  logic [7:0]  hs_keep;
  logic        hs_last;
  logic [15:0] inf_data;

  always @(negedge log_clk) begin
    if (nwr_valid_o) begin
      if (nv_cnt < 64) begin
        nv_addr[nv_cnt] = nwr_addr_o;
        nv_data[nv_cnt] = nwr_data_o;
      end
      nv_cnt = nv_cnt + 1;
    end
    if (nwr_done_o) begin
      done_cnt        = done_cnt + 1;
      done_bytes      = nwr_bytes_o;
      done_with_valid = nwr_valid_o;
    end
    if (nwr_err_o) err_cnt = err_cnt + 1;
    if (tresp_tvalid_o && tresp_tready_in) begin
      hs_cnt  = hs_cnt + 1;
      hs_data = tresp_tdata_o;
      hs_user = tresp_tuser_o;
      hs_keep = tresp_tkeep_o;
      hs_last = tresp_tlast_o;
    end
    if (db_inform_valid_o) begin
      inf_cnt  = inf_cnt + 1;
      inf_data = db_inform_o;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    nv_cnt = 0; done_cnt = 0; err_cnt = 0; hs_cnt = 0; inf_cnt = 0;
    done_bytes = '0; done_with_valid = 1'b0; hs_data = '0; hs_user = '0;
    hs_keep = '0; hs_last = 1'b0; inf_data = '0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge log_clk);
    #1;
  endtask

  function automatic logic [63:0] hdr(input logic [7:0] tid, input logic [3:0] ft,
                                      input logic [3:0] tt, input logic [1:0] pr,
                                      input logic [33:0] a);
    return {tid, ft, tt, 1'b0, pr, 1'b0, 8'h00, 2'b00, a};
  endfunction

  // Present one beat (called just after a rising edge); returns just after
  // the edge that accepted it.
  task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    int   n;
    logic acc;
    treq_tvalid_in = 1'b1;
    treq_tdata_in  = d;
    treq_tkeep_in  = k;
    treq_tlast_in  = l;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 100) begin
      @(negedge log_clk);
      acc = treq_tready_o;
      @(posedge log_clk);
      #1;
      n++;
    end
    check("beat_accept", {63'd0, acc}, 64'd1);
    treq_tvalid_in = 1'b0;
    treq_tlast_in  = 1'b0;
  endtask

  task automatic doorbell(input logic [7:0] tid, input logic [1:0] pr, input logic [15:0] info);
    beat(hdr(tid, 4'hA, 4'h0, pr, {2'b00, info, 16'h0000}), 8'hFF, 1'b1);
  endtask

  initial begin
    clr_mon();
    treq_tuser_in = 32'h0012_0000;   // requester ID 8'h12

    // ---- reset state ----
    cycles(2);
    check("rst_tready", {63'd0, treq_tready_o}, 64'd0);
    check("rst_tresp_valid", {63'd0, tresp_tvalid_o}, 64'd0);
    check("rst_tresp_data", tresp_tdata_o, 64'd0);
    check("rst_tresp_user", {32'd0, tresp_tuser_o}, 64'd0);
    check("rst_nwr", {nwr_valid_o, nwr_done_o, nwr_err_o, nwr_bytes_o, nwr_addr_o}, 64'd0);
    check("rst_inform", {47'd0, db_inform_valid_o, db_inform_o}, 64'd0);
    log_rst_n = 1'b1;
    cycles(1);
    check("idle_tready", {63'd0, treq_tready_o}, 64'd1);

    // ---- self-check doorbell, not busy ----
    tresp_tready_in = 1'b1;
    doorbell(8'h00, 2'd1, 16'h0101);
    check("db1_in_resp_tready", {63'd0, treq_tready_o}, 64'd0);
    cycles(1);
    check("db1_hs_cnt", hs_cnt, 1);
    check("db1_tdata", hs_data, 64'h00A0_4000_0100_0000);
    check("db1_tuser", {32'd0, hs_user}, 64'h00F0_0012);
    check("db1_keep_last", {55'd0, hs_keep, hs_last}, {55'd0, 8'hFF, 1'b1});
    check("db1_no_inform", inf_cnt, 0);
    check("db1_valid_low", {63'd0, tresp_tvalid_o}, 64'd0);

    // ---- self-check doorbell, busy, response backpressured 5 cycles ----
    clr_mon();
    target_busy_in  = 1'b1;
    tresp_tready_in = 1'b0;
    doorbell(8'h05, 2'd1, 16'h0101);
    target_busy_in = 1'b0;           // sampled at header accept only
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {63'd0, tresp_tvalid_o}, 64'd1);
      check("bp_tdata", tresp_tdata_o, 64'h05A0_4000_01FF_0000);
      check("bp_tready", {63'd0, treq_tready_o}, 64'd0);
      cycles(1);
    end
    tresp_tready_in = 1'b1;
    cycles(1);
    check("bp_hs_cnt", hs_cnt, 1);
    check("bp_hs_data", hs_data, 64'h05A0_4000_01FF_0000);
    check("bp_valid_drop", {63'd0, tresp_tvalid_o}, 64'd0);

    // ---- NWRITE 4 beats ----
    clr_mon();
    beat(hdr(8'h01, 4'h5, 4'h4, 2'd0, 34'h0_0010_0000), 8'hFF, 1'b0);
    beat(64'h1111_1111_1111_1111, 8'hFF, 1'b0);
    beat(64'h2222_2222_2222_2222, 8'hFF, 1'b0);
    beat(64'h3333_3333_3333_3333, 8'hFF, 1'b0);
    beat(64'h4444_4444_4444_4444, 8'h0F, 1'b1);
    cycles(1);
    check("nwr_cnt", nv_cnt, 4);
    check("nwr_addr0", {30'd0, nv_addr[0]}, 64'h10_0000);
    check("nwr_addr1", {30'd0, nv_addr[1]}, 64'h10_0008);
    check("nwr_addr2", {30'd0, nv_addr[2]}, 64'h10_0010);
    check("nwr_addr3", {30'd0, nv_addr[3]}, 64'h10_0018);
    check("nwr_data3", nv_data[3], 64'h4444_4444_4444_4444);
    check("nwr_done_cnt", done_cnt, 1);
    check("nwr_bytes", {52'd0, done_bytes}, 64'd28);
    check("nwr_done_aligned", {63'd0, done_with_valid}, 64'd1);
    check("nwr_no_err", err_cnt, 0);

    // ---- header-only NWRITE ----
    clr_mon();
    beat(hdr(8'h02, 4'h5, 4'h4, 2'd0, 34'h0_0000_4000), 8'hFF, 1'b1);
    cycles(1);
    check("nwr0_done", done_cnt, 1);
    check("nwr0_bytes", {52'd0, done_bytes}, 64'd0);
    check("nwr0_no_valid", nv_cnt, 0);

    // ---- integrity doorbell, prio saturates ----
    clr_mon();
    doorbell(8'h07, 2'd3, 16'h0201);
    cycles(1);
    check("dbi_hs_cnt", hs_cnt, 1);
    check("dbi_tdata", hs_data, 64'h07A0_6000_0201_0000);
    check("dbi_inform_cnt", inf_cnt, 1);
    check("dbi_inform_data", {48'd0, inf_data}, 64'h0201);

    // ---- multi-beat doorbell answered after the drop ----
    clr_mon();
    beat(hdr(8'h09, 4'hA, 4'h0, 2'd0, {2'b00, 16'h1234, 16'h0000}), 8'hFF, 1'b0);
    beat(64'hDEAD_BEEF_0000_0000, 8'hFF, 1'b1);
    cycles(1);
    check("dbm_hs_cnt", hs_cnt, 1);
    check("dbm_tdata", hs_data, 64'h09A0_2000_1234_0000);

    // ---- NWRITE overrun: 33 payload beats ----
    clr_mon();
    beat(hdr(8'h03, 4'h5, 4'h4, 2'd0, 34'h0_0000_2000), 8'hFF, 1'b0);
    for (int i = 0; i < 33; i++)
      beat(64'(i), 8'hFF, (i == 32));
    cycles(1);
    check("ovr_valid_cnt", nv_cnt, 32);
    check("ovr_last_addr", {30'd0, nv_addr[31]}, 64'h20F8);
    check("ovr_err_cnt", err_cnt, 1);
    check("ovr_no_done", done_cnt, 0);
    check("ovr_idle_tready", {63'd0, treq_tready_o}, 64'd1);

    // ---- unknown FTYPE, then a doorbell ----
    clr_mon();
    beat(hdr(8'h04, 4'h2, 4'h0, 2'd0, 34'h0), 8'hFF, 1'b0);
    beat(64'hAAAA_0000_0000_0000, 8'hFF, 1'b0);
    beat(64'hBBBB_0000_0000_0000, 8'hFF, 1'b1);
    cycles(1);
    check("unk_no_resp", hs_cnt + nv_cnt + done_cnt + err_cnt + inf_cnt, 0);
    check("unk_tvalid", {63'd0, tresp_tvalid_o}, 64'd0);
    doorbell(8'h33, 2'd0, 16'h0101);
    cycles(1);
    check("unk_db_hs", hs_cnt, 1);
    check("unk_db_tdata", hs_data, 64'h33A0_2000_0100_0000);

    // ---- reset in the middle of an NWRITE ----
    clr_mon();
    beat(hdr(8'h05, 4'h5, 4'h4, 2'd0, 34'h0_0000_8000), 8'hFF, 1'b0);
    beat(64'h5555_5555_5555_5555, 8'hFF, 1'b0);
    beat(64'h6666_6666_6666_6666, 8'hFF, 1'b0);
    check("mid_valid_before_rst", {63'd0, nwr_valid_o}, 64'd1);
    log_rst_n = 1'b0;
    #1;
    check("mid_rst_nwr", {nwr_valid_o, nwr_done_o, nwr_err_o, nwr_bytes_o, nwr_addr_o}, 64'd0);
    check("mid_rst_data", nwr_data_o, 64'd0);
    check("mid_rst_tready", {63'd0, treq_tready_o}, 64'd0);
    check("mid_rst_tresp", {63'd0, tresp_tvalid_o}, 64'd0);
    cycles(2);
    log_rst_n = 1'b1;
    cycles(1);
    clr_mon();
    doorbell(8'h44, 2'd2, 16'h0101);
    cycles(1);
    check("post_rst_hs", hs_cnt, 1);
    check("post_rst_tdata", hs_data, 64'h44A0_6000_0100_0000);
    check("post_rst_no_nwr", nv_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
